// File: rtl/pc_redirect_ctrl_if.sv
// PC-redirect control bus: pipeline/interrupt inputs and PC-register control outputs.
interface pc_redirect_ctrl_if;
  logic [15:0] arch_pc;
  logic        br_valid;
  logic [15:0] br_target;
  logic        nmi;
  logic        int_req;
  logic        ei;
  logic        di;
  logic        retn;
  logic        fetch_stall;
  logic        pc_update;
  logic [15:0] target_pc;
  logic        pipe_stall;
  logic        flush;
  logic        int_ack;
  logic        int_is_nmi;
  logic [15:0] ret_pc;
  logic        iff1;
  logic        iff2;

  modport slave (
    input  arch_pc, br_valid, br_target, nmi, int_req, ei, di, retn, fetch_stall,
    output pc_update, target_pc, pipe_stall, flush, int_ack, int_is_nmi, ret_pc, iff1, iff2
  );

  modport master (
    output arch_pc, br_valid, br_target, nmi, int_req, ei, di, retn, fetch_stall,
    input  pc_update, target_pc, pipe_stall, flush, int_ack, int_is_nmi, ret_pc, iff1, iff2
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Sequences branch redirects and NMI/IM1 interrupt entry for the PC register,
// owning IFF1/IFF2 and capturing the return PC.
module pc_redirect_ctrl #(
  parameter logic [15:0] NMI_VEC      = 16'h0066,
  parameter logic [15:0] INT_VEC      = 16'h0038,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic               clk_i,
  input logic               rst_i,
  pc_redirect_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, DRAIN, VECTOR} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kind_q, kind_d;
  logic             nmi_d_q;
  logic             nmi_pend_q, nmi_pend_d;
  logic             ei_block_q;
  logic [15:0]      ret_pc_q, ret_pc_d;
  logic             iff1_q, iff1_d;
  logic             iff2_q, iff2_d;

  logic nmi_edge, nmi_req, int_take, accept, vec_go;

  // An edge in the accept cycle counts as pending so NMI keeps priority over INT.
  assign nmi_edge = bus.nmi & ~nmi_d_q;
  assign nmi_req  = nmi_pend_q | nmi_edge;
  assign int_take = bus.int_req & iff1_q & ~ei_block_q & ~bus.ei & ~bus.di;
  assign accept   = (state_q == IDLE) & (nmi_req | int_take) & ~bus.fetch_stall;
  assign vec_go   = (state_q == VECTOR) & ~bus.fetch_stall;

  // Zero-latency PC-register controls, forced low while reset is held.
  always_comb begin
    bus.pc_update  = 1'b0;
    bus.target_pc  = 16'h0000;
    bus.pipe_stall = 1'b0;
    bus.flush      = 1'b0;
    bus.int_ack    = 1'b0;
    bus.int_is_nmi = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          bus.pc_update  = bus.br_valid;
          bus.target_pc  = bus.br_valid ? bus.br_target : 16'h0000;
          bus.pipe_stall = bus.fetch_stall;
        end
        DRAIN: begin
          bus.pipe_stall = 1'b1;
          bus.pc_update  = bus.br_valid;
          bus.target_pc  = bus.br_valid ? bus.br_target : 16'h0000;
        end
        VECTOR: begin
          bus.pc_update  = 1'b1;
          bus.target_pc  = kind_q ? NMI_VEC : INT_VEC;
          bus.pipe_stall = bus.fetch_stall;
          bus.flush      = ~bus.fetch_stall;
          bus.int_ack    = ~bus.fetch_stall;
          bus.int_is_nmi = ~bus.fetch_stall & kind_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    ret_pc_d   = ret_pc_q;
    nmi_pend_d = nmi_pend_q | nmi_edge;
    iff1_d     = iff1_q;
    iff2_d     = iff2_q;

    if (bus.retn) iff1_d = iff2_q;
    if (bus.ei) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end
    if (bus.di) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          kind_d   = nmi_req;
          ret_pc_d = bus.br_valid ? bus.br_target : bus.arch_pc;
          cnt_d    = CNT_W'(DRAIN_CYCLES - 1);
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.br_valid) ret_pc_d = bus.br_target;
        if (cnt_q == '0) state_d = VECTOR;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      VECTOR: begin
        if (vec_go) begin
          if (kind_q) begin
            iff2_d     = iff1_q;
            iff1_d     = 1'b0;
            nmi_pend_d = nmi_edge;
          end else begin
            iff1_d = 1'b0;
            iff2_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kind_q     <= 1'b0;
      nmi_d_q    <= 1'b0;
      nmi_pend_q <= 1'b0;
      ei_block_q <= 1'b0;
      ret_pc_q   <= 16'h0000;
      iff1_q     <= 1'b0;
      iff2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      nmi_d_q    <= bus.nmi;
      nmi_pend_q <= nmi_pend_d;
      ei_block_q <= bus.ei;
      ret_pc_q   <= ret_pc_d;
      iff1_q     <= iff1_d;
      iff2_q     <= iff2_d;
    end
  end

  assign bus.ret_pc = ret_pc_q;
  assign bus.iff1   = iff1_q;
  assign bus.iff2   = iff2_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences every non-sequential update of the architectural PC register: branch redirects, NMI entry and maskable-interrupt entry (IM1).
- Drives the PC register's update, target and stall inputs.
- Owns the interrupt-enable flip-flops IFF1/IFF2.
- Drains the in-flight pipeline before vectoring, and captures the return PC for the push logic.

Parameters:
- NMI_VEC, 16'h0066, NMI target address.
- INT_VEC, 16'h0038, maskable interrupt target address (IM1).
- DRAIN_CYCLES, 3, cycles the pipeline is held before vectoring; legal range 1..7.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- arch_pc  in  16  current architectural PC from the PC register.
- br_valid  in  1  a resolved taken branch this cycle.
- br_target  in  16  branch destination.
- nmi  in  1  NMI line; rising-edge sensitive.
- int_req  in  1  maskable interrupt request; level sensitive.
- ei  in  1  EI instruction retires this cycle.
- di  in  1  DI instruction retires this cycle.
- retn  in  1  RETN retires this cycle.
- fetch_stall  in  1  external fetch or memory stall.
- pc_update  out  1  select target_pc as the next PC.
- target_pc  out  16  redirect address.
- pipe_stall  out  1  freeze the PC and fetch.
- flush  out  1  squash the fetched, not-yet-issued instructions.
- int_ack  out  1  one-cycle interrupt acknowledge.
- int_is_nmi  out  1  qualifies int_ack.
- ret_pc  out  16  return address to push.
- iff1  out  1  interrupt enable flip-flop 1.
- iff2  out  1  interrupt enable flip-flop 2.

Behaviour:

Reset and general rules:
- RST asserted (asynchronous): state=IDLE, drain counter=0, nmi_pend=0, nmi_d=0, ei_block=0, ret_pc=0, iff1=iff2=0.
- While reset is held, all outputs are 0 (pc_update, target_pc, pipe_stall, flush, int_ack, int_is_nmi, ret_pc, iff1, iff2).
- Reset mid-DRAIN or mid-VECTOR aborts the entry; nothing stays pending.
- NMI edge detection: nmi_d<=nmi every cycle; nmi & ~nmi_d sets nmi_pend.
- nmi_pend is cleared only in the VECTOR cycle that takes the NMI.
- If a new edge arrives in that same cycle, nmi_pend stays set.
- int_take = int_req & iff1 & ~ei_block & ~di.
- ei: iff1,iff2<=1 and ei_block<=1 for one cycle, so no INT is accepted in the EI cycle or the next cycle.
- di: iff1,iff2<=0 immediately; di wins over a simultaneous int_req.
- retn: iff1<=iff2.

IDLE state:
- pc_update and target_pc are combinational, with zero latency: br_valid gives pc_update=1, target_pc=br_target. Otherwise pc_update=0 and target_pc=0.
- pipe_stall=fetch_stall.
- If nmi_pend or int_take, and fetch_stall=0, accept the interrupt:
  - latch kind (NMI has priority over INT);
  - ret_pc<=br_valid ? br_target : arch_pc;
  - counter<=DRAIN_CYCLES-1;
  - go to DRAIN.
- A branch in the accept cycle still redirects the PC.

DRAIN state:
- pipe_stall=1; pc_update=0 except on a branch.
- br_valid (an in-flight branch resolving) sets pc_update=1, target_pc=br_target and ret_pc<=br_target. The PC holds because of the stall.
- Counter decrements each cycle; at 0, go to VECTOR.
- A new NMI edge during an INT drain stays pending and is taken after return to IDLE.

VECTOR state:
- pc_update=1; target_pc=NMI_VEC or INT_VEC; pipe_stall=fetch_stall.
- If fetch_stall=1, remain in VECTOR with no side effects.
- Otherwise, in that single cycle:
  - flush=1, int_ack=1, int_is_nmi=kind;
  - NMI: iff2<=iff1, iff1<=0, nmi_pend cleared;
  - INT: iff1,iff2<=0;
  - next state is IDLE.
- br_valid in VECTOR is ignored; the pipeline is already drained.

Width and stability:
- All addresses are 16-bit with no arithmetic, so no wrap handling is needed.
- ret_pc holds its value until the next accept.

Test Plan:
1. Reset release, then br_valid=1 with br_target=16'h1234 in IDLE → same-cycle pc_update=1, target_pc=16'h1234, pipe_stall=0.
2. ei, then int_req=1 from the next cycle, arch_pc=16'h0200, DRAIN_CYCLES=3 → INT not accepted for ei_block. Then pipe_stall=1 for 3 cycles, then one VECTOR cycle: pc_update=1, target_pc=16'h0038, flush=1, int_ack=1, int_is_nmi=0, ret_pc=16'h0200, iff1=iff2=0.
3. iff1=1, nmi rising edge and int_req the same cycle → NMI vectored (16'h0066, int_is_nmi=1), iff2 retains 1, iff1=0. A later retn restores iff1=1, and the still-high int_req is then taken.
4. Branch to 16'h4000 during DRAIN → ret_pc=16'h4000. fetch_stall=1 while in VECTOR → vector held with int_ack=0 until stall drops, then a single int_ack pulse.
5. di and int_req=1 in the same cycle with iff1=1 → no accept, iff1=0. An nmi held high stays at one entry (edge only).
6. RST asserted mid-DRAIN → outputs immediately 0, state IDLE; after release no vector is issued.
